// File: rtl/flags_unit.sv
// flags_unit: processor status word with EQ/GT/LT compare, Z/N flags,
// interrupt-mask ownership and a small LIFO save stack for interrupt entry/return.
module flags_unit #(
  parameter int unsigned        WIDTH       = 16,
  parameter int unsigned        STACK_DEPTH = 4,
  parameter logic [WIDTH-1:0]   RESET_FLAGS = WIDTH'(16'h0004),
  localparam int unsigned       CNT_W       = $clog2(STACK_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             compare,
  input  logic             cmp_signed,
  input  logic             load,
  input  logic             mask_int,
  input  logic             unmask_int,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] bus1,
  input  logic [WIDTH-1:0] bus2,
  output logic [WIDTH-1:0] flags,
  output logic [CNT_W-1:0] stack_count,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             stack_err
);

  localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam int unsigned B_EQ = 0;
  localparam int unsigned B_GT = 1;
  localparam int unsigned B_IM = 2;
  localparam int unsigned B_LT = 3;
  localparam int unsigned B_Z  = 4;
  localparam int unsigned B_N  = 5;

  logic [WIDTH-1:0] flags_q, flags_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] stack_q [STACK_DEPTH];

  logic             full_c, empty_c;
  logic             push_ok_c, pop_ok_c, swap_ok_c;
  logic             stk_we_c;
  logic [IDX_W-1:0] stk_idx_c, top_idx_c;
  logic             eq_c, gt_c, lt_c;

  assign full_c    = (count_q == CNT_W'(STACK_DEPTH));
  assign empty_c   = (count_q == '0);
  assign top_idx_c = IDX_W'(count_q - CNT_W'(1));

  // Compare results for the selected signedness mode
  always_comb begin
    eq_c = (bus1 == bus2);
    if (cmp_signed) begin
      gt_c = ($signed(bus1) > $signed(bus2));
      lt_c = ($signed(bus1) < $signed(bus2));
    end else begin
      gt_c = (bus1 > bus2);
      lt_c = (bus1 < bus2);
    end
  end

  // Next-state: data-path priority, IM override, stack bookkeeping
  always_comb begin
    flags_d   = flags_q;
    count_d   = count_q;
    err_d     = err_q;
    stk_we_c  = 1'b0;
    stk_idx_c = IDX_W'(count_q);

    push_ok_c = push && !pop && !full_c;
    pop_ok_c  = pop && !push && !empty_c;
    swap_ok_c = push && pop && !empty_c;

    if (pop_ok_c || swap_ok_c) begin
      flags_d = stack_q[top_idx_c];
    end else if (load) begin
      flags_d = bus1;
    end else if (compare) begin
      flags_d[B_EQ] = eq_c;
      flags_d[B_GT] = gt_c;
      flags_d[B_LT] = lt_c;
      flags_d[B_Z]  = (bus1 == '0);
      flags_d[B_N]  = bus1[WIDTH-1];
    end

    // Interrupt mask has its own priority on top of the data path
    if (mask_int)        flags_d[B_IM] = 1'b1;
    else if (unmask_int) flags_d[B_IM] = 1'b0;
    else if (push)       flags_d[B_IM] = 1'b1;

    if (push_ok_c) begin
      stk_we_c  = 1'b1;
      stk_idx_c = IDX_W'(count_q);
      count_d   = count_q + CNT_W'(1);
    end else if (swap_ok_c) begin
      stk_we_c  = 1'b1;
      stk_idx_c = top_idx_c;
    end else if (pop_ok_c) begin
      count_d   = count_q - CNT_W'(1);
    end

    // Pop on empty (alone or as swap) and push on full are sticky errors
    if ((pop && empty_c) || (push && !pop && full_c)) err_d = 1'b1;
  end

  // Status word, occupancy and sticky error registers
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= RESET_FLAGS;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // Save-stack storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (!rst && stk_we_c) stack_q[stk_idx_c] <= flags_q;
  end

  assign flags       = flags_q;
  assign stack_count = count_q;
  assign stack_full  = full_c;
  assign stack_empty = empty_c;
  assign stack_err   = err_q;

endmodule

// File: tb/tb_flags_unit.sv
// Bench for flags_unit: directed scenarios plus randomized run against a queue-based model.
module tb_flags_unit;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst, compare, cmp_signed, load, mask_int, unmask_int, push, pop;
  logic [WIDTH-1:0] bus1, bus2;
  logic [WIDTH-1:0] flags;
  logic [CNT_W-1:0] stack_count;
  logic             stack_full, stack_empty, stack_err;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [15:0] m_flags;
  logic [15:0] m_stack[$];
  logic        m_err;

  flags_unit #(.WIDTH(WIDTH), .STACK_DEPTH(DEPTH), .RESET_FLAGS(16'h0004)) dut (
    .clk(clk), .rst(rst), .compare(compare), .cmp_signed(cmp_signed), .load(load),
    .mask_int(mask_int), .unmask_int(unmask_int), .push(push), .pop(pop),
    .bus1(bus1), .bus2(bus2), .flags(flags), .stack_count(stack_count),
    .stack_full(stack_full), .stack_empty(stack_empty), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  task automatic idle();
    rst = 0; compare = 0; cmp_signed = 0; load = 0; mask_int = 0; unmask_int = 0;
    push = 0; pop = 0; bus1 = '0; bus2 = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle(); rst = 1; step(); idle();
    n_vec++; if (flags !== 16'h0004) begin n_err++; $display("FAIL reset_flags got=%h exp=0004", flags); end
    n_vec++; if (stack_count !== 0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", stack_count); end
    n_vec++; if (stack_empty !== 1'b1 || stack_full !== 1'b0) begin n_err++; $display("FAIL reset_empty_full got=%b%b exp=10", stack_empty, stack_full); end
    n_vec++; if (stack_err !== 1'b0) begin n_err++; $display("FAIL reset_err got=%b exp=0", stack_err); end
  endtask

  task automatic test_compare();
    idle(); compare = 1; bus1 = 16'hFFFF; bus2 = 16'h0001; cmp_signed = 0; step();
    n_vec++; if (flags !== 16'h0026) begin n_err++; $display("FAIL cmp_unsigned got=%h exp=0026", flags); end
    cmp_signed = 1; step();
    n_vec++; if (flags !== 16'h002C) begin n_err++; $display("FAIL cmp_signed got=%h exp=002c", flags); end
    bus1 = 0; bus2 = 0; cmp_signed = 0; step();
    n_vec++; if (flags !== 16'h0015) begin n_err++; $display("FAIL cmp_equal_zero got=%h exp=0015", flags); end
    idle();
  endtask

  task automatic test_priority();
    idle(); load = 1; compare = 1; bus1 = 16'h1230; bus2 = 16'h0001; step();
    n_vec++; if (flags !== 16'h1230) begin n_err++; $display("FAIL load_over_compare got=%h exp=1230", flags); end
    idle(); load = 1; mask_int = 1; unmask_int = 0; bus1 = 16'h0000; step();
    n_vec++; if (flags !== 16'h0004) begin n_err++; $display("FAIL mask_over_load got=%h exp=0004", flags); end
    idle(); mask_int = 1; unmask_int = 1; load = 1; bus1 = 16'h0100; step();
    n_vec++; if (flags !== 16'h0104) begin n_err++; $display("FAIL mask_beats_unmask got=%h exp=0104", flags); end
    idle();
  endtask

  task automatic test_nesting();
    idle(); rst = 1; step(); idle();
    load = 1; bus1 = 16'h00A0; step(); idle();
    push = 1; step(); idle();
    n_vec++; if (flags !== 16'h00A4 || stack_count !== 1) begin n_err++; $display("FAIL nest_push1 got=%h/%0d exp=00a4/1", flags, stack_count); end
    load = 1; bus1 = 16'h0050; step(); idle();
    push = 1; step(); idle();
    n_vec++; if (stack_count !== 2) begin n_err++; $display("FAIL nest_push2 got=%0d exp=2", stack_count); end
    pop = 1; step(); idle();
    n_vec++; if (flags !== 16'h0050 || stack_count !== 1) begin n_err++; $display("FAIL nest_pop1 got=%h/%0d exp=0050/1", flags, stack_count); end
    pop = 1; step(); idle();
    n_vec++; if (flags !== 16'h00A0 || stack_count !== 0 || stack_err !== 1'b0) begin n_err++; $display("FAIL nest_pop2 got=%h/%0d/%b exp=00a0/0/0", flags, stack_count, stack_err); end
  endtask

  task automatic test_overflow();
    idle();
    for (int i = 0; i < 4; i++) begin push = 1; step(); end
    n_vec++; if (stack_count !== 4 || stack_full !== 1'b1 || stack_err !== 1'b0) begin n_err++; $display("FAIL ovf_fill got=%0d/%b/%b exp=4/1/0", stack_count, stack_full, stack_err); end
    push = 1; step(); idle();
    n_vec++; if (stack_count !== 4 || stack_err !== 1'b1) begin n_err++; $display("FAIL ovf_fifth got=%0d/%b exp=4/1", stack_count, stack_err); end
    rst = 1; step(); idle();
    pop = 1; compare = 1; bus1 = 16'h0005; bus2 = 16'h0005; step(); idle();
    n_vec++; if (flags !== 16'h0005 || stack_count !== 0 || stack_err !== 1'b1) begin n_err++; $display("FAIL udf_pop got=%h/%0d/%b exp=0005/0/1", flags, stack_count, stack_err); end
  endtask

  task automatic test_back_to_back();
    idle(); rst = 1; step(); idle();
    load = 1; bus1 = 16'h0011; step(); idle();
    push = 1; step(); idle();
    load = 1; bus1 = 16'h0020; step(); idle();
    push = 1; pop = 1; step(); idle();
    n_vec++; if (flags !== 16'h0015 || stack_count !== 1) begin n_err++; $display("FAIL swap got=%h/%0d exp=0015/1", flags, stack_count); end
    pop = 1; step(); idle();
    n_vec++; if (flags !== 16'h0020 || stack_count !== 0) begin n_err++; $display("FAIL swap_top got=%h/%0d exp=0020/0", flags, stack_count); end
    push = 1; pop = 1; step(); idle();
    n_vec++; if (stack_err !== 1'b1 || stack_count !== 0 || flags !== 16'h0024) begin n_err++; $display("FAIL swap_empty got=%h/%0d/%b exp=0024/0/1", flags, stack_count, stack_err); end
    push = 1; step();
    rst = 1; push = 1; step(); idle();
    n_vec++; if (stack_count !== 0 || flags !== 16'h0004 || stack_err !== 1'b0) begin n_err++; $display("FAIL rst_with_push got=%h/%0d/%b exp=0004/0/0", flags, stack_count, stack_err); end
  endtask

  // Model: next flags/stack/error from the current inputs using plain arithmetic
  task automatic model_apply();
    logic [15:0] nf;
    int a, b;
    if (rst) begin
      m_flags = 16'h0004; m_stack.delete(); m_err = 0;
      return;
    end
    nf = m_flags;
    if (pop && m_stack.size() > 0) begin
      nf = m_stack[m_stack.size()-1];
      if (push) m_stack[m_stack.size()-1] = m_flags;
      else void'(m_stack.pop_back());
    end else begin
      if (pop) m_err = 1;
      if (load) nf = bus1;
      else if (compare) begin
        a = int'(bus1); b = int'(bus2);
        if (cmp_signed && bus1[15]) a = a - 65536;
        if (cmp_signed && bus2[15]) b = b - 65536;
        nf[0] = (a == b); nf[1] = (a > b); nf[3] = (a < b);
        nf[4] = (bus1 == 0); nf[5] = bus1[15];
      end
      if (push && !pop) begin
        if (m_stack.size() < DEPTH) m_stack.push_back(m_flags);
        else m_err = 1;
      end
    end
    if (mask_int) nf[2] = 1;
    else if (unmask_int) nf[2] = 0;
    else if (push) nf[2] = 1;
    m_flags = nf;
  endtask

  task automatic test_random();
    idle(); rst = 1; model_apply(); step();
    for (int i = 0; i < 600; i++) begin
      idle();
      rst        = ($urandom_range(0, 59) == 0);
      load       = ($urandom_range(0, 5) == 0);
      compare    = ($urandom_range(0, 1) == 0);
      cmp_signed = $urandom_range(0, 1);
      push       = ($urandom_range(0, 3) == 0);
      pop        = ($urandom_range(0, 3) == 0);
      mask_int   = ($urandom_range(0, 7) == 0);
      unmask_int = ($urandom_range(0, 7) == 0);
      bus1 = 16'($urandom); bus2 = 16'($urandom);
      case ($urandom_range(0, 3))
        0: bus2 = bus1;
        1: bus1 = '0;
        default: ;
      endcase
      model_apply();
      step();
      n_vec++; if (flags !== m_flags) begin n_err++; $display("FAIL rnd_flags i=%0d got=%h exp=%h", i, flags, m_flags); end
      n_vec++; if (int'(stack_count) != m_stack.size()) begin n_err++; $display("FAIL rnd_count i=%0d got=%0d exp=%0d", i, stack_count, m_stack.size()); end
      n_vec++; if (stack_full !== (m_stack.size() == DEPTH)) begin n_err++; $display("FAIL rnd_full i=%0d got=%b", i, stack_full); end
      n_vec++; if (stack_empty !== (m_stack.size() == 0)) begin n_err++; $display("FAIL rnd_empty i=%0d got=%b", i, stack_empty); end
      n_vec++; if (stack_err !== m_err) begin n_err++; $display("FAIL rnd_err i=%0d got=%b exp=%b", i, stack_err, m_err); end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_compare();
    test_priority();
    test_nesting();
    test_overflow();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/flags_unit.md
Name: flags_unit

Overview:
- Parametrised successor to the CPU comparator/flags register.
- Holds the processor status word and produces separate EQ, GT and LT results, in signed or unsigned mode, plus zero and negative flags.
- Owns the interrupt-mask bit.
- Adds a small hardware save stack so the interrupt entry/return sequencer can push and pop the status word without touching memory.

Parameters:
- WIDTH, 16, data and flags word width (min 8).
- STACK_DEPTH, 4, number of saved flag words (min 1).
- RESET_FLAGS, 16'h0004, flags value after reset (interrupts masked).
- CNT_W, $clog2(STACK_DEPTH+1), width of the stack occupancy count (derived, not overridden).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- compare  in  1  update compare/status bits from bus1/bus2
- cmp_signed  in  1  1 = two's-complement compare, 0 = unsigned; sampled with compare
- load  in  1  flags <= bus1
- mask_int  in  1  set IM
- unmask_int  in  1  clear IM
- push  in  1  save flags to stack
- pop  in  1  restore flags from stack
- bus1  in  WIDTH  operand A / load data
- bus2  in  WIDTH  operand B
- flags  out  WIDTH  status word, registered
- stack_count  out  CNT_W  number of saved words
- stack_full  out  1  stack_count == STACK_DEPTH
- stack_empty  out  1  stack_count == 0
- stack_err  out  1  sticky overflow/underflow flag

Behaviour:
- Flag layout:
  - bit0 EQ (bus1==bus2)
  - bit1 GT (bus1>bus2 per mode)
  - bit2 IM (interrupt mask)
  - bit3 LT (bus1<bus2 per mode)
  - bit4 Z (bus1==0)
  - bit5 N (bus1[WIDTH-1])
  - bits WIDTH-1:6 general purpose, written only by load/pop.
- Reset (rst=1 at edge):
  - flags=RESET_FLAGS, stack_count=0, stack_err=0.
  - Stack contents are don't-care.
  - rst overrides every other input, including mid-sequence push/pop.
- Latency: all outputs registered; the effect of any command is visible the cycle after the sampling edge. stack_full/stack_empty decode from registered stack_count.
- Data-path priority for bits other than IM, highest first:
  1. pop (or swap)
  2. load
  3. compare
  4. hold
- compare writes bits 0,1,3,4,5 only. Exactly one of EQ/GT/LT is 1 after a compare; other bits hold.
- cmp_signed=1 compares $signed operands; cmp_signed=0 compares unsigned.
- IM (bit2) final value, evaluated after the data-path update:
  1. mask_int → 1
  2. else unmask_int → 0
  3. else push (accepted or not) → 1 (auto-mask on interrupt entry)
  4. else the value from pop/load, or held.
  - mask_int and unmask_int together: mask wins.
- Push only (accepted when !stack_full):
  - stack[stack_count] <= flags (value before this edge, IM as it was).
  - stack_count += 1.
  - When full: no write, count unchanged, stack_err <= 1, auto-mask still applies.
- Pop only (accepted when !stack_empty):
  - flags <= stack[stack_count-1], subject to the IM override rule above.
  - stack_count -= 1.
  - When empty: flags follow load/compare priority as if pop were absent, stack_err <= 1.
- Push and pop together (swap):
  - If !stack_empty: flags <= top entry, top entry <= current flags, count unchanged. IM then follows rule 3 (forced 1) unless mask/unmask.
  - If empty: treated as a failed pop plus push-when-empty? No: the whole swap is rejected, stack_err <= 1, flags follow load/compare, IM rule 3 applies.
- stack_err clears only on rst.
- Stack is LIFO; no wrap-around. The count never exceeds STACK_DEPTH and never goes below 0.

Test Plan:
1. Reset: rst for 1 cycle → flags=0x0004, stack_count=0, stack_empty=1, stack_full=0, stack_err=0.
2. Compare modes: bus1=0xFFFF, bus2=0x0001, compare, cmp_signed=0 → flags[5:0]=6'b100110 (N,IM,GT). Same operands with cmp_signed=1 → LT=1, GT=0, EQ=0. bus1=bus2=0 → EQ=1, Z=1.
3. Priority: load=1, compare=1, bus1=0x1230 → flags=0x1230. load=1, unmask_int=0, mask_int=1, bus1=0x0000 → flags=0x0004.
4. Push/pop nesting (STACK_DEPTH=4):
   - load 0x00A0, then push → flags=0x00A4, count=1.
   - load 0x0050, push → count=2.
   - pop → flags=0x00A4?? no: flags=0x0050, count=1.
   - pop → flags=0x00A0, count=0, stack_err=0.
5. Overflow/underflow:
   - 5 consecutive pushes → count saturates at 4, stack_full=1, stack_err=1 from the 5th.
   - After rst, pop on empty with compare=1 → compare result applied, count=0, stack_err=1.
6. Swap and reset mid-operation:
   - With count=1, top=0x0011, flags=0x0020: push+pop → flags=0x0015 (IM forced), top=0x0020, count=1.
   - rst asserted together with push → count=0, flags=0x0004.
